// File: rtl/crossbar_2m2s_core.sv
// Two-master / two-slave request/ack crossbar.
// Address MSB selects the slave; each slave has its own round-robin arbiter.
module crossbar_2m2s_core #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          master_1_req,
  input  logic          master_1_cmd,
  input  logic [AW-1:0] master_1_addr,
  input  logic [DW-1:0] master_1_wdata,
  output logic          master_1_ack,
  output logic [DW-1:0] master_1_rdata,
  input  logic          master_2_req,
  input  logic          master_2_cmd,
  input  logic [AW-1:0] master_2_addr,
  input  logic [DW-1:0] master_2_wdata,
  output logic          master_2_ack,
  output logic [DW-1:0] master_2_rdata,
  output logic          slave_1_req,
  output logic          slave_1_cmd,
  output logic [AW-1:0] slave_1_addr,
  output logic [DW-1:0] slave_1_wdata,
  input  logic          slave_1_ack,
  input  logic [DW-1:0] slave_1_rdata,
  output logic          slave_2_req,
  output logic          slave_2_cmd,
  output logic [AW-1:0] slave_2_addr,
  output logic [DW-1:0] slave_2_wdata,
  input  logic          slave_2_ack,
  input  logic [DW-1:0] slave_2_rdata
);

  logic [1:0]      sel;
  logic [1:0][1:0] rq;
  logic [1:0]      sack;
  logic [1:0]      own_v;
  logic [1:0]      own_id;
  logic [1:0]      ptr;
  logic [1:0]      gv;
  logic [1:0]      gid;

  assign sel   = {master_2_addr[AW-1], master_1_addr[AW-1]};
  assign rq[0] = {master_2_req & ~sel[1], master_1_req & ~sel[0]};
  assign rq[1] = {master_2_req &  sel[1], master_1_req &  sel[0]};
  assign sack  = {slave_2_ack, slave_1_ack};

  // rq[s][n]: master n (0=M1) is requesting slave s (0=S1)
  always_comb begin
    gv  = '0;
    gid = '0;
    for (int s = 0; s < 2; s++) begin
      if (own_v[s] && rq[s][own_id[s]]) begin
        gv[s]  = 1'b1;
        gid[s] = own_id[s];
      end else begin
        unique case (rq[s])
          2'b01: begin
            gv[s]  = 1'b1;
            gid[s] = 1'b0;
          end
          2'b10: begin
            gv[s]  = 1'b1;
            gid[s] = 1'b1;
          end
          2'b11: begin
            gv[s]  = 1'b1;
            gid[s] = ptr[s];
          end
          default: begin
            gv[s]  = 1'b0;
            gid[s] = 1'b0;
          end
        endcase
      end
    end
  end

  // Lock owner until ack; on completion hand priority to the other master
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_v  <= '0;
      own_id <= '0;
      ptr    <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (gv[s] && sack[s]) begin
          own_v[s] <= 1'b0;
          ptr[s]   <= ~gid[s];
        end else if (gv[s]) begin
          own_v[s]  <= 1'b1;
          own_id[s] <= gid[s];
        end else begin
          own_v[s] <= 1'b0;
        end
      end
    end
  end

  assign slave_1_req   = gv[0];
  assign slave_1_cmd   = gv[0] & (gid[0] ? master_2_cmd : master_1_cmd);
  assign slave_1_addr  = !gv[0] ? '0 :
                         (gid[0] ? master_2_addr : master_1_addr);
  assign slave_1_wdata = !gv[0] ? '0 :
                         (gid[0] ? master_2_wdata : master_1_wdata);

  assign slave_2_req   = gv[1];
  assign slave_2_cmd   = gv[1] & (gid[1] ? master_2_cmd : master_1_cmd);
  assign slave_2_addr  = !gv[1] ? '0 :
                         (gid[1] ? master_2_addr : master_1_addr);
  assign slave_2_wdata = !gv[1] ? '0 :
                         (gid[1] ? master_2_wdata : master_1_wdata);

  logic [1:0] g1;
  logic [1:0] g2;

  assign g1 = {gv[1] & ~gid[1], gv[0] & ~gid[0]};
  assign g2 = {gv[1] &  gid[1], gv[0] &  gid[0]};

  assign master_1_ack   = |(g1 & sack);
  assign master_2_ack   = |(g2 & sack);
  assign master_1_rdata = ({DW{g1[0]}} & slave_1_rdata) |
                          ({DW{g1[1]}} & slave_2_rdata);
  assign master_2_rdata = ({DW{g2[0]}} & slave_1_rdata) |
                          ({DW{g2[1]}} & slave_2_rdata);

endmodule

// File: tb/tb_crossbar_2m2s_core.sv
// Directed self-checking bench for crossbar_2m2s_core.
// Each task drives one scenario and checks hand-computed values inline.
module tb_crossbar_2m2s_core;

  logic        clk = 0;
  logic        rst;
  logic        m1_req, m1_cmd, m2_req, m2_cmd;
  logic [31:0] m1_addr, m1_wdata, m2_addr, m2_wdata;
  logic        m1_ack, m2_ack;
  logic [31:0] m1_rdata, m2_rdata;
  logic        s1_req, s1_cmd, s2_req, s2_cmd;
  logic [31:0] s1_addr, s1_wdata, s2_addr, s2_wdata;
  logic        s1_ack, s2_ack;
  logic [31:0] s1_rdata, s2_rdata;

  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  crossbar_2m2s_core #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .master_1_req(m1_req), .master_1_cmd(m1_cmd),
    .master_1_addr(m1_addr), .master_1_wdata(m1_wdata),
    .master_1_ack(m1_ack), .master_1_rdata(m1_rdata),
    .master_2_req(m2_req), .master_2_cmd(m2_cmd),
    .master_2_addr(m2_addr), .master_2_wdata(m2_wdata),
    .master_2_ack(m2_ack), .master_2_rdata(m2_rdata),
    .slave_1_req(s1_req), .slave_1_cmd(s1_cmd),
    .slave_1_addr(s1_addr), .slave_1_wdata(s1_wdata),
    .slave_1_ack(s1_ack), .slave_1_rdata(s1_rdata),
    .slave_2_req(s2_req), .slave_2_cmd(s2_cmd),
    .slave_2_addr(s2_addr), .slave_2_wdata(s2_wdata),
    .slave_2_ack(s2_ack), .slave_2_rdata(s2_rdata)
  );

  task automatic idle();
    m1_req = 0; m1_cmd = 0; m1_addr = 0; m1_wdata = 0;
    m2_req = 0; m2_cmd = 0; m2_addr = 0; m2_wdata = 0;
    s1_ack = 0; s2_ack = 0; s1_rdata = 0; s2_rdata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({s1_req, s2_req, m1_ack, m2_ack} !== 4'b0000) $display("FAIL reset_ctl got %b exp 0000", {s1_req, s2_req, m1_ack, m2_ack});
    else pass++;
    total++;
    if ({s1_addr, s1_wdata, s2_addr, s2_wdata} !== 128'h0) $display("FAIL reset_data got %h exp 0", {s1_addr, s1_wdata, s2_addr, s2_wdata});
    else pass++;
  endtask

  task automatic test_single_writes();
    logic [31:0] a, d;
    logic        tgt_req, oth_req, tgt_cmd, mack, oack;
    logic [31:0] tgt_wd, tgt_ad;
    for (int i = 0; i < 4; i++) begin
      idle();
      a = (i % 2 == 1) ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      d = (i >= 2) ? 32'h2222_2222 : 32'h1111_1111;
      if (i < 2) begin
        m1_req = 1; m1_cmd = 1; m1_addr = a; m1_wdata = d;
      end else begin
        m2_req = 1; m2_cmd = 1; m2_addr = a; m2_wdata = d;
      end
      #1;
      tgt_req = (i % 2 == 1) ? s2_req : s1_req;
      oth_req = (i % 2 == 1) ? s1_req : s2_req;
      tgt_cmd = (i % 2 == 1) ? s2_cmd : s1_cmd;
      tgt_wd  = (i % 2 == 1) ? s2_wdata : s1_wdata;
      tgt_ad  = (i % 2 == 1) ? s2_addr : s1_addr;
      total++;
      if ({tgt_req, oth_req, tgt_cmd} !== 3'b101) $display("FAIL wr%0d_req got %b exp 101", i, {tgt_req, oth_req, tgt_cmd});
      else pass++;
      total++;
      if (tgt_wd !== d) $display("FAIL wr%0d_wdata got %h exp %h", i, tgt_wd, d);
      else pass++;
      total++;
      if (tgt_ad !== a) $display("FAIL wr%0d_addr got %h exp %h", i, tgt_ad, a);
      else pass++;
      total++;
      if ({m1_ack, m2_ack} !== 2'b00) $display("FAIL wr%0d_noack got %b exp 00", i, {m1_ack, m2_ack});
      else pass++;
      if (i % 2 == 1) s2_ack = 1; else s1_ack = 1;
      #1;
      mack = (i < 2) ? m1_ack : m2_ack;
      oack = (i < 2) ? m2_ack : m1_ack;
      total++;
      if ({mack, oack} !== 2'b10) $display("FAIL wr%0d_ack got %b exp 10", i, {mack, oack});
      else pass++;
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_single_reads();
    idle();
    m1_req = 1; m1_addr = 32'h7FFF_FFFF;
    s1_rdata = 32'h1000_0001; s2_rdata = 32'hDEAD_BEEF; s1_ack = 1;
    #1;
    total++;
    if (m1_rdata !== 32'h1000_0001) $display("FAIL rd1_rdata got %h exp 10000001", m1_rdata);
    else pass++;
    total++;
    if (m2_rdata !== 32'h0) $display("FAIL rd1_other got %h exp 0", m2_rdata);
    else pass++;
    total++;
    if ({s1_req, s1_cmd, m1_ack} !== 3'b101) $display("FAIL rd1_ctl got %b exp 101", {s1_req, s1_cmd, m1_ack});
    else pass++;
    tick();
    idle();
    m2_req = 1; m2_addr = 32'hFFFF_FFFF;
    s2_rdata = 32'h2000_0002; s1_rdata = 32'hDEAD_BEEF; s2_ack = 1;
    #1;
    total++;
    if (m2_rdata !== 32'h2000_0002) $display("FAIL rd2_rdata got %h exp 20000002", m2_rdata);
    else pass++;
    total++;
    if (m1_rdata !== 32'h0) $display("FAIL rd2_other got %h exp 0", m1_rdata);
    else pass++;
    tick();
    idle();
    tick();
  endtask

  task automatic test_parallel();
    idle();
    m1_req = 1; m1_cmd = 1; m1_addr = 32'h7FFF_FFFF; m1_wdata = 32'h1111_1111;
    m2_req = 1; m2_cmd = 1; m2_addr = 32'hFFFF_FFFF; m2_wdata = 32'h2222_2222;
    #1;
    total++;
    if ({s1_req, s2_req} !== 2'b11) $display("FAIL par_req got %b exp 11", {s1_req, s2_req});
    else pass++;
    total++;
    if ({s1_wdata, s2_wdata} !== {32'h1111_1111, 32'h2222_2222}) $display("FAIL par_wdata got %h exp 1111111122222222", {s1_wdata, s2_wdata});
    else pass++;
    s1_ack = 1; s2_ack = 1;
    #1;
    total++;
    if ({m1_ack, m2_ack} !== 2'b11) $display("FAIL par_ack got %b exp 11", {m1_ack, m2_ack});
    else pass++;
    tick();
    idle();
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    m1_req = 1; m1_cmd = 1; m1_addr = 32'h7FFF_FFFF; m1_wdata = 32'h1111_1111;
    m2_req = 1; m2_cmd = 1; m2_addr = 32'h1FFF_FFFF; m2_wdata = 32'h1111_2222;
    s1_ack = 1;
    #1;
    total++;
    if (s1_wdata !== 32'h1111_1111) $display("FAIL cont1_wdata got %h exp 11111111", s1_wdata);
    else pass++;
    total++;
    if ({m1_ack, m2_ack, s2_req} !== 3'b100) $display("FAIL cont1_ack got %b exp 100", {m1_ack, m2_ack, s2_req});
    else pass++;
    tick();
    total++;
    if (s1_wdata !== 32'h1111_2222) $display("FAIL cont2_wdata got %h exp 11112222", s1_wdata);
    else pass++;
    total++;
    if ({m1_ack, m2_ack} !== 2'b01) $display("FAIL cont2_ack got %b exp 01", {m1_ack, m2_ack});
    else pass++;
    tick();
    idle();
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    m1_req = 1; m1_cmd = 1; m1_addr = 32'h0000_0010; m1_wdata = 32'hAAAA_0001;
    s1_ack = 1;
    tick();
    s1_ack = 0;
    m1_wdata = 32'hAAAA_0002;
    tick();
    m2_req = 1; m2_cmd = 0; m2_addr = 32'h0000_0020; m2_wdata = 32'hBBBB_0001;
    #1;
    total++;
    if ({s1_wdata, s1_cmd} !== {32'hAAAA_0002, 1'b1}) $display("FAIL lock_hold got %h exp aaaa00021", {s1_wdata, s1_cmd});
    else pass++;
    tick();
    total++;
    if (s1_addr !== 32'h0000_0010) $display("FAIL lock_hold2 got %h exp 00000010", s1_addr);
    else pass++;
    s1_ack = 1;
    #1;
    total++;
    if ({m1_ack, m2_ack} !== 2'b10) $display("FAIL lock_ack got %b exp 10", {m1_ack, m2_ack});
    else pass++;
    tick();
    m1_req = 0; s1_ack = 0;
    #1;
    total++;
    if ({s1_addr, s1_cmd} !== {32'h0000_0020, 1'b0}) $display("FAIL lock_next got %h exp 000000200", {s1_addr, s1_cmd});
    else pass++;
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_req = 1; m1_cmd = 1; m1_addr = 32'h0000_0004; m1_wdata = 32'h1111_1111;
    s1_ack = 1;
    tick();
    idle();
    m2_req = 1; m2_cmd = 1; m2_addr = 32'h0000_0008; m2_wdata = 32'h2222_2222;
    tick();
    m1_req = 1; m1_cmd = 1; m1_addr = 32'h0000_0004; m1_wdata = 32'h1111_1111;
    #1;
    total++;
    if (s1_wdata !== 32'h2222_2222) $display("FAIL rstmid_lock got %h exp 22222222", s1_wdata);
    else pass++;
    rst = 1;
    #1;
    total++;
    if (s1_wdata !== 32'h1111_1111) $display("FAIL rstmid_clear got %h exp 11111111", s1_wdata);
    else pass++;
    tick();
    rst = 0;
    s1_ack = 1;
    #1;
    total++;
    if ({m1_ack, m2_ack} !== 2'b10) $display("FAIL rstmid_ack got %b exp 10", {m1_ack, m2_ack});
    else pass++;
    tick();
    idle();
    tick();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_single_writes();
    test_single_reads();
    test_parallel();
    test_contention();
    test_lock();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
